// File: rtl/wb_hazard_scoreboard_if.sv
// Issue/read/retire bundle for the WB hazard scoreboard.
//   master: ID/EX issue request, ID source reads, WB retire; observes the outputs
//   slave : scoreboard side; drives o_stall, o_pending, o_err, o_stall_cnt
interface wb_hazard_scoreboard_if #(
    parameter int unsigned PERF_W = 16
);
    logic              i_issue_valid;
    logic              i_issue_wren;
    logic [4:0]        i_issue_rd;
    logic [4:0]        i_rs1_addr;
    logic              i_rs1_used;
    logic [4:0]        i_rs2_addr;
    logic              i_rs2_used;
    logic              i_wb_wren;
    logic [4:0]        i_wb_rd;
    logic              o_stall;
    logic [31:0]       o_pending;
    logic              o_err;
    logic [PERF_W-1:0] o_stall_cnt;

    modport master (
        output i_issue_valid, i_issue_wren, i_issue_rd,
        output i_rs1_addr, i_rs1_used, i_rs2_addr, i_rs2_used,
        output i_wb_wren, i_wb_rd,
        input  o_stall, o_pending, o_err, o_stall_cnt
    );

    modport slave (
        input  i_issue_valid, i_issue_wren, i_issue_rd,
        input  i_rs1_addr, i_rs1_used, i_rs2_addr, i_rs2_used,
        input  i_wb_wren, i_wb_rd,
        output o_stall, o_pending, o_err, o_stall_cnt
    );
endinterface

// File: rtl/wb_hazard_scoreboard.sv
// Pending-write scoreboard for the non-forwarding pipeline. Counts writes that
// issued past ID and have not retired through WB, and stalls decode while a
// source register still has one outstanding.
//   i_clk, i_rst     : clock, synchronous active-low reset
//   bus (slave)      : issue request, ID source reads, WB retire in;
//                      o_stall (combinational), o_pending, o_err (sticky),
//                      o_stall_cnt (saturating) out
module wb_hazard_scoreboard #(
    parameter int unsigned CNT_W     = 2,
    parameter bit          WB_BYPASS = 1'b1,
    parameter int unsigned PERF_W    = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    wb_hazard_scoreboard_if.slave  bus
);
    localparam int unsigned NREG = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];
    logic              err_q;
    logic              err_d;
    logic [PERF_W-1:0] stall_cnt_q;

    logic [NREG-1:0]   retire_hit;
    logic [NREG-1:0]   issue_hit;
    logic [NREG-1:0]   hazard;
    logic [NREG-1:0]   pending;
    logic              stall;
    logic              iss;

    // Per-register retire match, pending flag and hazard; x0 is never tracked.
    always_comb begin
        retire_hit = '0;
        pending    = '0;
        hazard     = '0;
        for (int r = 0; r < NREG; r++) begin
            retire_hit[r] = bus.i_wb_wren && (bus.i_wb_rd == 5'(r)) && (r != 0);
            pending[r]    = (r != 0) && (cnt_q[r] != '0);
            // With a write-first register file the retiring write is already visible.
            if (WB_BYPASS && retire_hit[r]) begin
                hazard[r] = (r != 0) && (cnt_q[r] > CNT_W'(1));
            end else begin
                hazard[r] = pending[r];
            end
        end
    end

    // Decode stall and the effective issue it gates.
    always_comb begin
        stall = (bus.i_rs1_used && (bus.i_rs1_addr != '0) && hazard[bus.i_rs1_addr]) ||
                (bus.i_rs2_used && (bus.i_rs2_addr != '0) && hazard[bus.i_rs2_addr]);
        iss   = bus.i_issue_valid && !stall && bus.i_issue_wren && (bus.i_issue_rd != '0);
        issue_hit = '0;
        for (int r = 0; r < NREG; r++) begin
            issue_hit[r] = iss && (bus.i_issue_rd == 5'(r)) && (r != 0);
        end
    end

    // Counter next state; simultaneous issue and retire cancel out.
    always_comb begin
        err_d = err_q;
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            case ({issue_hit[r], retire_hit[r]})
                2'b10: begin
                    if (cnt_q[r] == CNT_MAX) err_d = 1'b1;
                    else                     cnt_d[r] = cnt_q[r] + CNT_W'(1);
                end
                2'b01: begin
                    if (cnt_q[r] == '0) err_d = 1'b1;
                    else                cnt_d[r] = cnt_q[r] - CNT_W'(1);
                end
                default: cnt_d[r] = cnt_q[r];
            endcase
        end
    end

    // State registers; reset drops all pending state without draining.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
            err_q <= err_d;
            if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + PERF_W'(1);
        end
    end

    assign bus.o_stall     = stall;
    assign bus.o_pending   = pending;
    assign bus.o_err       = err_q;
    assign bus.o_stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_wb_hazard_scoreboard.sv
// Bench for wb_hazard_scoreboard: two instances (WB_BYPASS=1 and 0) fed the same
// directed vectors; expected responses are queued by the stimulus and popped by
// a monitor on the falling edge.
module tb_wb_hazard_scoreboard;
    localparam int unsigned PERF_W = 16;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wb_hazard_scoreboard_if #(.PERF_W(PERF_W)) bus1 ();
    wb_hazard_scoreboard_if #(.PERF_W(PERF_W)) bus0 ();

    wb_hazard_scoreboard #(.CNT_W(2), .WB_BYPASS(1'b1), .PERF_W(PERF_W)) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1.slave)
    );

    wb_hazard_scoreboard #(.CNT_W(2), .WB_BYPASS(1'b0), .PERF_W(PERF_W)) dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus0.slave)
    );

    typedef struct {
        string       name;
        logic        stall1;
        logic        stall0;
        logic [31:0] pend;
        logic        err;
        int          sc1;
        int          sc0;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string nm, input string fld,
                         input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic iv, input logic iw, input logic [4:0] ird,
                         input logic [4:0] a1, input logic u1,
                         input logic [4:0] a2, input logic u2,
                         input logic ww, input logic [4:0] wrd);
        bus1.i_issue_valid = iv;  bus0.i_issue_valid = iv;
        bus1.i_issue_wren  = iw;  bus0.i_issue_wren  = iw;
        bus1.i_issue_rd    = ird; bus0.i_issue_rd    = ird;
        bus1.i_rs1_addr    = a1;  bus0.i_rs1_addr    = a1;
        bus1.i_rs1_used    = u1;  bus0.i_rs1_used    = u1;
        bus1.i_rs2_addr    = a2;  bus0.i_rs2_addr    = a2;
        bus1.i_rs2_used    = u2;  bus0.i_rs2_used    = u2;
        bus1.i_wb_wren     = ww;  bus0.i_wb_wren     = ww;
        bus1.i_wb_rd       = wrd; bus0.i_wb_rd       = wrd;
    endtask

    // One cycle: apply inputs, queue the expected outputs for this cycle, advance.
    task automatic step(input string nm,
                        input logic iv, input logic iw, input logic [4:0] ird,
                        input logic [4:0] a1, input logic u1,
                        input logic [4:0] a2, input logic u2,
                        input logic ww, input logic [4:0] wrd,
                        input logic s1, input logic s0, input logic [31:0] p,
                        input logic e, input int c1, input int c0);
        exp_t t;
        drive(iv, iw, ird, a1, u1, a2, u2, ww, wrd);
        t.name = nm; t.stall1 = s1; t.stall0 = s0; t.pend = p;
        t.err = e; t.sc1 = c1; t.sc0 = c0;
        exp_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check(cur.name, "stall_b1",    32'(bus1.o_stall),     32'(cur.stall1));
            check(cur.name, "stall_b0",    32'(bus0.o_stall),     32'(cur.stall0));
            check(cur.name, "pending_b1",  bus1.o_pending,        cur.pend);
            check(cur.name, "pending_b0",  bus0.o_pending,        cur.pend);
            check(cur.name, "err_b1",      32'(bus1.o_err),       32'(cur.err));
            check(cur.name, "err_b0",      32'(bus0.o_err),       32'(cur.err));
            check(cur.name, "stallcnt_b1", 32'(bus1.o_stall_cnt), 32'(cur.sc1));
            check(cur.name, "stallcnt_b0", 32'(bus0.o_stall_cnt), 32'(cur.sc0));
        end
    end

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        //    name        iv iw ird a1 u1 a2 u2 ww wrd s1 s0 pend      err c1 c0
        step("idle_rs1",  0, 0, 0,  5, 1, 0, 0, 0, 0,  0, 0, 32'h0,   0,  0, 0);

        // RAW on x5: issue, stall until WB retire
        step("haz_c0",    1, 1, 5,  0, 0, 0, 0, 0, 0,  0, 0, 32'h0,   0,  0, 0);
        step("haz_c1",    0, 0, 0,  5, 1, 0, 0, 0, 0,  1, 1, 32'h20,  0,  0, 0);
        step("haz_c2",    0, 0, 0,  5, 1, 0, 0, 0, 0,  1, 1, 32'h20,  0,  1, 1);
        step("haz_c3",    0, 0, 0,  5, 1, 0, 0, 1, 5,  0, 1, 32'h20,  0,  2, 2);
        step("haz_c4",    0, 0, 0,  5, 1, 0, 0, 0, 0,  0, 0, 32'h0,   0,  2, 3);

        // Three writes in flight to x7, then three retires
        step("cnt7_a",    1, 1, 7,  0, 0, 0, 0, 0, 0,  0, 0, 32'h0,   0,  2, 3);
        step("cnt7_b",    1, 1, 7,  0, 0, 0, 0, 0, 0,  0, 0, 32'h80,  0,  2, 3);
        step("cnt7_c",    1, 1, 7,  0, 0, 0, 0, 0, 0,  0, 0, 32'h80,  0,  2, 3);
        step("cnt7_d",    0, 0, 0,  0, 0, 0, 0, 1, 7,  0, 0, 32'h80,  0,  2, 3);
        step("cnt7_e",    0, 0, 0,  7, 1, 0, 0, 1, 7,  1, 1, 32'h80,  0,  2, 3);
        step("cnt7_f",    0, 0, 0,  7, 1, 0, 0, 1, 7,  0, 1, 32'h80,  0,  3, 4);
        step("cnt7_g",    0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 32'h0,   0,  3, 5);

        // Same-cycle issue+retire on x9; stalled issue must not count
        step("rd9_h",     1, 1, 9,  0, 0, 0, 0, 0, 0,  0, 0, 32'h0,   0,  3, 5);
        step("rd9_i",     1, 1, 9,  0, 0, 0, 0, 1, 9,  0, 0, 32'h200, 0,  3, 5);
        step("rd9_j",     1, 1, 9,  0, 0, 9, 1, 0, 0,  1, 1, 32'h200, 0,  3, 5);
        step("rd9_k",     0, 0, 0,  0, 0, 0, 0, 1, 9,  0, 0, 32'h200, 0,  4, 6);
        step("rd9_l",     0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 32'h0,   0,  4, 6);

        // x0 is never tracked
        step("x0_m",      1, 1, 0,  0, 1, 0, 1, 0, 0,  0, 0, 32'h0,   0,  4, 6);
        step("x0_n",      0, 0, 0,  0, 1, 0, 1, 1, 0,  0, 0, 32'h0,   0,  4, 6);
        step("x0_o",      0, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 32'h0,   0,  4, 6);

        // Retire underflow on x4 sets sticky error
        step("err_p",     0, 0, 0,  0, 0, 0, 0, 1, 4,  0, 0, 32'h0,   0,  4, 6);
        step("err_q",     1, 1, 3,  0, 0, 0, 0, 0, 0,  0, 0, 32'h0,   1,  4, 6);
        step("err_r",     0, 0, 0,  0, 0, 0, 0, 1, 3,  0, 0, 32'h8,   1,  4, 6);
        step("err_t",     1, 1, 3,  0, 0, 0, 0, 0, 0,  0, 0, 32'h0,   1,  4, 6);

        // Mid-run reset with x3 pending
        do_reset();
        step("post_rst",  0, 0, 0,  3, 1, 0, 0, 0, 0,  0, 0, 32'h0,   0,  0, 0);
        step("post_rst2", 0, 0, 0,  3, 1, 0, 0, 0, 0,  0, 0, 32'h0,   0,  0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
